component_stats_collector: RTL



---
 rtl/component_stats_collector_if.sv | 47 ++++
 rtl/component_stats_collector.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/component_stats_collector_if.sv
// Bundles the pixel stream, the label-merge channel and the object record
// stream of component_stats_collector. The slave modport is the collector's view.
interface component_stats_collector_if #(
  parameter int LABEL_W = 8,
  parameter int COORD_W = 16,
  parameter int AREA_W  = 24
);
  logic               en;
  logic [LABEL_W-1:0] label;
  logic [31:0]        x;
  logic [31:0]        y;
  logic               frame_end;
  logic               merge_valid;
  logic               merge_ready;
  logic [LABEL_W-1:0] merge_from;
  logic [LABEL_W-1:0] merge_into;
  logic               merge_done;
  logic               obj_valid;
  logic               obj_ready;
  logic [LABEL_W-1:0] obj_label;
  logic [AREA_W-1:0]  obj_area;
  logic [COORD_W-1:0] obj_min_x;
  logic [COORD_W-1:0] obj_max_x;
  logic [COORD_W-1:0] obj_min_y;
  logic [COORD_W-1:0] obj_max_y;
  logic               obj_last;
  logic               busy;
  logic               drop_err;

  modport slave (
    input  en, label, x, y, frame_end,
    input  merge_valid, merge_from, merge_into, merge_done,
    output merge_ready,
    input  obj_ready,
    output obj_valid, obj_label, obj_area, obj_min_x, obj_max_x, obj_min_y, obj_max_y, obj_last,
    output busy, drop_err
  );

  modport master (
    output en, label, x, y, frame_end,
    output merge_valid, merge_from, merge_into, merge_done,
    input  merge_ready,
    output obj_ready,
    input  obj_valid, obj_label, obj_area, obj_min_x, obj_max_x, obj_min_y, obj_max_y, obj_last,
    input  busy, drop_err
  );
endinterface

// File: rtl/component_stats_collector.sv
// Per-label area/bounding-box accumulator: CLEAR -> ACCUM (pixels) -> MERGE
// (fold equivalent labels) -> EMIT (one record per surviving label) -> CLEAR.
module component_stats_collector #(
  parameter int LABEL_W    = 8,
  parameter int NUM_LABELS = 256,
  parameter int COORD_W    = 16,
  parameter int AREA_W     = 24
) (
  input logic                   clk,
  input logic                   reset_n,
  component_stats_collector_if.slave s
);

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_MERGE, S_EMIT} state_t;

  localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_LABELS - 1);

  state_t r_state, w_next;

  logic [AREA_W-1:0]  r_area  [NUM_LABELS];
  logic [COORD_W-1:0] r_min_x [NUM_LABELS];
  logic [COORD_W-1:0] r_max_x [NUM_LABELS];
  logic [COORD_W-1:0] r_min_y [NUM_LABELS];
  logic [COORD_W-1:0] r_max_y [NUM_LABELS];

  // One index serves as the clear pointer and as the emit scan index.
  logic [LABEL_W-1:0] r_idx;
  logic               r_obj_valid, r_obj_last, r_drop_err;
  logic [LABEL_W-1:0] r_obj_label;
  logic [AREA_W-1:0]  r_obj_area;
  logic [COORD_W-1:0] r_obj_min_x, r_obj_max_x, r_obj_min_y, r_obj_max_y;

  logic [COORD_W-1:0] w_cx, w_cy;
  logic               w_pix, w_mrg_apply, w_cur_nz, w_more;
  logic [LABEL_W-1:0] w_fi, w_ti;
  logic [AREA_W:0]    w_sum;
  logic [AREA_W-1:0]  w_sum_sat, w_inc_sat;
  logic               w_unused_hi;

  assign w_cx        = s.x[COORD_W-1:0];
  assign w_cy        = s.y[COORD_W-1:0];
  assign w_unused_hi = ^{s.x[31:COORD_W], s.y[31:COORD_W]};
  assign w_pix       = (r_state == S_ACCUM) && s.en && (s.label != '0);
  assign w_inc_sat   = (&r_area[s.label]) ? r_area[s.label] : r_area[s.label] + 1'b1;

  assign w_fi        = s.merge_from;
  assign w_ti        = s.merge_into;
  assign w_mrg_apply = (r_state == S_MERGE) && s.merge_valid &&
                       (w_fi != w_ti) && (w_fi != '0) && (w_ti != '0);
  assign w_sum       = {1'b0, r_area[w_ti]} + {1'b0, r_area[w_fi]};
  assign w_sum_sat   = w_sum[AREA_W] ? '1 : w_sum[AREA_W-1:0];

  assign w_cur_nz    = (r_area[r_idx] != '0);

  // Look-ahead so the record of the highest occupied label carries obj_last.
  always_comb begin
    w_more = 1'b0;
    for (int i = 1; i < NUM_LABELS; i++)
      if ((LABEL_W'(i) > r_idx) && (r_area[i] != '0)) w_more = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (r_idx == LAST_IDX) w_next = S_ACCUM;
      S_ACCUM: if (s.frame_end) w_next = S_MERGE;
      S_MERGE: if (s.merge_done) w_next = S_EMIT;
      S_EMIT: begin
        if (r_obj_valid) begin
          if (s.obj_ready && r_obj_last) w_next = S_CLEAR;
        end else if (!w_cur_nz && (r_idx == LAST_IDX)) begin
          w_next = S_CLEAR;
        end
      end
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_obj_valid <= 1'b0;
      r_obj_last  <= 1'b0;
      r_drop_err  <= 1'b0;
      r_obj_label <= '0;
      r_obj_area  <= '0;
      r_obj_min_x <= '0;
      r_obj_max_x <= '0;
      r_obj_min_y <= '0;
      r_obj_max_y <= '0;
    end else begin
      if (s.en && (r_state != S_ACCUM)) r_drop_err <= 1'b1;
      case (r_state)
        S_CLEAR: r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        S_MERGE: if (s.merge_done) r_idx <= LABEL_W'(1);
        S_EMIT: begin
          if (r_obj_valid) begin
            if (s.obj_ready) begin
              r_obj_valid <= 1'b0;
              r_obj_last  <= 1'b0;
              r_idx       <= r_obj_last ? '0 : r_idx + 1'b1;
            end
          end else if (w_cur_nz) begin
            r_obj_valid <= 1'b1;
            r_obj_last  <= !w_more;
            r_obj_label <= r_idx;
            r_obj_area  <= r_area[r_idx];
            r_obj_min_x <= r_min_x[r_idx];
            r_obj_max_x <= r_max_x[r_idx];
            r_obj_min_y <= r_min_y[r_idx];
            r_obj_max_y <= r_max_y[r_idx];
          end else begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Table storage has no reset; CLEAR initialises it one entry per cycle.
  always_ff @(posedge clk) begin
    case (r_state)
      S_CLEAR: begin
        r_area[r_idx]  <= '0;
        r_min_x[r_idx] <= '1;
        r_max_x[r_idx] <= '0;
        r_min_y[r_idx] <= '1;
        r_max_y[r_idx] <= '0;
      end
      S_ACCUM: if (w_pix) begin
        r_area[s.label]  <= w_inc_sat;
        r_min_x[s.label] <= (w_cx < r_min_x[s.label]) ? w_cx : r_min_x[s.label];
        r_max_x[s.label] <= (w_cx > r_max_x[s.label]) ? w_cx : r_max_x[s.label];
        r_min_y[s.label] <= (w_cy < r_min_y[s.label]) ? w_cy : r_min_y[s.label];
        r_max_y[s.label] <= (w_cy > r_max_y[s.label]) ? w_cy : r_max_y[s.label];
      end
      S_MERGE: if (w_mrg_apply) begin
        r_area[w_ti]  <= w_sum_sat;
        r_min_x[w_ti] <= (r_min_x[w_fi] < r_min_x[w_ti]) ? r_min_x[w_fi] : r_min_x[w_ti];
        r_max_x[w_ti] <= (r_max_x[w_fi] > r_max_x[w_ti]) ? r_max_x[w_fi] : r_max_x[w_ti];
        r_min_y[w_ti] <= (r_min_y[w_fi] < r_min_y[w_ti]) ? r_min_y[w_fi] : r_min_y[w_ti];
        r_max_y[w_ti] <= (r_max_y[w_fi] > r_max_y[w_ti]) ? r_max_y[w_fi] : r_max_y[w_ti];
        r_area[w_fi]  <= '0;
        r_min_x[w_fi] <= '1;
        r_max_x[w_fi] <= '0;
        r_min_y[w_fi] <= '1;
        r_max_y[w_fi] <= '0;
      end
      default: ;
    endcase
  end

  assign s.merge_ready = (r_state == S_MERGE);
  assign s.busy        = (r_state != S_ACCUM);
  assign s.drop_err    = r_drop_err;
  assign s.obj_valid   = r_obj_valid;
  assign s.obj_last    = r_obj_last;
  assign s.obj_label   = r_obj_label;
  assign s.obj_area    = r_obj_area;
  assign s.obj_min_x   = r_obj_min_x;
  assign s.obj_max_x   = r_obj_max_x;
  assign s.obj_min_y   = r_obj_min_y;
  assign s.obj_max_y   = r_obj_max_y;

endmodule
